// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: PC-1/PC-2 tables, shift schedule, FSM states
// and the small permutation/rotation helpers used by the schedule datapath.
package des_pkg;

    localparam int unsigned KEY_W    = 64;
    localparam int unsigned CD_W     = 56;
    localparam int unsigned HALF_W   = 28;
    localparam int unsigned SUBKEY_W = 48;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ks_state_e;

    // Bit i set means round i rotates by one position, otherwise by two.
    localparam logic [15:0] SHIFT_ONE = 16'h8103;

    localparam int unsigned PC1 [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2 [SUBKEY_W] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    function automatic logic [1:0] shift_amt(input logic [3:0] idx);
        return SHIFT_ONE[idx] ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [1:CD_W] pc1(input logic [1:KEY_W] k);
        logic [1:CD_W] r;
        for (int i = 0; i < int'(CD_W); i++) r[i+1] = k[PC1[i]];
        return r;
    endfunction

    function automatic logic [1:SUBKEY_W] pc2(input logic [1:CD_W] cd);
        logic [1:SUBKEY_W] r;
        for (int i = 0; i < int'(SUBKEY_W); i++) r[i+1] = cd[PC2[i]];
        return r;
    endfunction

    // Bit 1 is the MSB, so a left rotation moves bit 1 to the tail.
    function automatic logic [1:HALF_W] rotl28(input logic [1:HALF_W] c, input logic [1:0] n);
        return (n == 2'd1) ? {c[2:28], c[1]} : {c[3:28], c[1:2]};
    endfunction

    function automatic logic [1:HALF_W] rotr28(input logic [1:HALF_W] c, input logic [1:0] n);
        return (n == 2'd1) ? {c[28], c[1:27]} : {c[27:28], c[1:26]};
    endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Key-in / subkey-out handshake bundle of the DES key schedule.
interface des_key_schedule_if;
    import des_pkg::*;

    logic                key_valid;
    logic                key_ready;
    logic [1:KEY_W]      key;
    logic                decrypt;
    logic                subkey_valid;
    logic                subkey_ready;
    logic [1:SUBKEY_W]   subkey;
    logic [3:0]          round;
    logic                last;
    logic                busy;

    modport master (
        output key_valid, key, decrypt, subkey_ready,
        input  key_ready, subkey_valid, subkey, round, last, busy
    );

    modport slave (
        input  key_valid, key, decrypt, subkey_ready,
        output key_ready, subkey_valid, subkey, round, last, busy
    );

endinterface

// File: rtl/des_keyrotate.sv
// Combinational 28-bit left rotate of one key half by the shift schedule entry s(index).
module des_keyrotate
    import des_pkg::*;
(
    input  logic [1:HALF_W] din,
    input  logic [3:0]      index,
    output logic [1:HALF_W] dout_c
);

    assign dout_c = rotl28(din, shift_amt(index));

endmodule

// File: rtl/des_keyrotate_rev.sv
// Combinational 28-bit right rotate of one key half by s(index); undoes des_keyrotate.
module des_keyrotate_rev
    import des_pkg::*;
(
    input  logic [1:HALF_W] din,
    input  logic [3:0]      index,
    output logic [1:HALF_W] dout_c
);

    assign dout_c = rotr28(din, shift_amt(index));

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: captures a key, then streams sixteen PC-2 subkeys,
// forward (K1..K16) or reverse (K16..K1), one per output handshake.
module des_key_schedule
    import des_pkg::*;
#(
    parameter bit SUPPORT_DECRYPT = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    des_key_schedule_if.slave  bus
);

    ks_state_e          state_q, state_d;
    logic [1:CD_W]      cd_q, cd_d;
    logic [1:SUBKEY_W]  sk_q, sk_d;
    logic [3:0]         round_q, round_d;
    logic               mode_q, mode_d;
    logic               key_ready_q, valid_q, busy_q, last_q;
    logic               upd;

    logic               decrypt_eff;
    logic [3:0]         round_inc;
    logic [3:0]         round_rev;
    logic [1:CD_W]      key_pc1;
    logic [1:CD_W]      load_cd;
    logic [1:HALF_W]    c_fwd, d_fwd, c_rev, d_rev;

    assign decrypt_eff = SUPPORT_DECRYPT & bus.decrypt;
    assign round_inc   = round_q + 4'd1;
    assign round_rev   = 4'd15 - round_q;
    assign key_pc1     = pc1(bus.key);

    // Decrypt starts from CD0, which equals CD16 after the full 28-position rotation.
    assign load_cd = decrypt_eff ? key_pc1
                                 : {rotl28(key_pc1[1:28],  shift_amt(4'd0)),
                                    rotl28(key_pc1[29:56], shift_amt(4'd0))};

    des_keyrotate u_rot_c (.din(cd_q[1:28]),  .index(round_inc), .dout_c(c_fwd));
    des_keyrotate u_rot_d (.din(cd_q[29:56]), .index(round_inc), .dout_c(d_fwd));

    generate
        if (SUPPORT_DECRYPT) begin : g_rev
            des_keyrotate_rev u_rev_c (.din(cd_q[1:28]),  .index(round_rev), .dout_c(c_rev));
            des_keyrotate_rev u_rev_d (.din(cd_q[29:56]), .index(round_rev), .dout_c(d_rev));
        end else begin : g_norev
            assign c_rev = '0;
            assign d_rev = '0;
        end
    endgenerate

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        sk_d    = sk_q;
        round_d = round_q;
        mode_d  = mode_q;
        upd     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.key_valid) begin
                    cd_d    = load_cd;
                    round_d = 4'd0;
                    mode_d  = decrypt_eff;
                    state_d = RUN;
                    upd     = 1'b1;
                end
            end
            RUN: begin
                if (bus.subkey_ready) begin
                    if (round_q == 4'd15) begin
                        state_d = IDLE;
                    end else begin
                        cd_d    = mode_q ? {c_rev, d_rev} : {c_fwd, d_fwd};
                        round_d = round_inc;
                        upd     = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (upd) sk_d = pc2(cd_d);
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cd_q        <= '0;
            sk_q        <= '0;
            round_q     <= 4'd0;
            mode_q      <= 1'b0;
            key_ready_q <= 1'b1;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cd_q        <= cd_d;
            sk_q        <= sk_d;
            round_q     <= round_d;
            mode_q      <= mode_d;
            key_ready_q <= (state_d == IDLE);
            valid_q     <= (state_d == RUN);
            busy_q      <= (state_d == RUN);
            last_q      <= (state_d == RUN) && (round_d == 4'd15);
        end
    end

    assign bus.key_ready    = key_ready_q;
    assign bus.subkey_valid = valid_q;
    assign bus.subkey       = sk_q;
    assign bus.round        = round_q;
    assign bus.last         = last_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule against the classic 0x133457799BBCDFF1 subkey table.
module tb_des_key_schedule;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    des_key_schedule_if bus();

    des_key_schedule #(.SUPPORT_DECRYPT(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B = 64'h123456789ABCDEF0;
    localparam logic [63:0] KEY_X = 64'h0E329232EA6D0D73;

    int n_tests = 0;
    int n_fail  = 0;
    logic [47:0] ks [16];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " key_ready"},    64'(bus.key_ready),    64'd1);
        check({tag, " subkey_valid"}, 64'(bus.subkey_valid), 64'd0);
        check({tag, " subkey"},       64'(bus.subkey),       64'd0);
        check({tag, " round"},        64'(bus.round),        64'd0);
        check({tag, " last"},         64'(bus.last),         64'd0);
        check({tag, " busy"},         64'(bus.busy),         64'd0);
    endtask

    // Wait (bounded) for key_ready, then hold key_valid for exactly one edge.
    task automatic load_key(input logic [63:0] k, input logic dec);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!bus.key_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("key_ready before load", 64'(bus.key_ready), 64'd1);
        bus.key       = k;
        bus.decrypt   = dec;
        bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    // Walk the subkey stream; optional stall, foreign-key pulse, or early stop (-1 = none).
    task automatic collect(input string tag, input logic dec, input int stall_r,
                           input int stall_n, input int pulse_r, input int stop_r);
        int e;
        for (int r = 0; r < 16; r++) begin
            e = dec ? 15 - r : r;
            check($sformatf("%s valid r%0d", tag, r),  64'(bus.subkey_valid), 64'd1);
            check($sformatf("%s subkey r%0d", tag, r), 64'(bus.subkey),       64'(ks[e]));
            check($sformatf("%s round r%0d", tag, r),  64'(bus.round),        64'(r));
            check($sformatf("%s last r%0d", tag, r),   64'(bus.last),         64'(r == 15));
            if (r == 0) check($sformatf("%s busy", tag), 64'(bus.busy), 64'd1);
            if (r == stop_r) return;
            if (r == pulse_r) begin
                bus.key       = KEY_X;
                bus.decrypt   = ~dec;
                bus.key_valid = 1'b1;
                check($sformatf("%s key_ready in run", tag), 64'(bus.key_ready), 64'd0);
            end
            if (r == stall_r) begin
                bus.subkey_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge clk);
                    check($sformatf("%s hold subkey s%0d", tag, s), 64'(bus.subkey),       64'(ks[e]));
                    check($sformatf("%s hold round s%0d", tag, s),  64'(bus.round),        64'(r));
                    check($sformatf("%s hold valid s%0d", tag, s),  64'(bus.subkey_valid), 64'd1);
                end
                bus.subkey_ready = 1'b1;
            end
            @(negedge clk);
            bus.key_valid = 1'b0;
        end
        check($sformatf("%s end valid", tag),     64'(bus.subkey_valid), 64'd0);
        check($sformatf("%s end key_ready", tag), 64'(bus.key_ready),    64'd1);
        check($sformatf("%s end busy", tag),      64'(bus.busy),         64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        ks = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
               48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
               48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
               48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
        rst_n            = 1'b0;
        bus.key_valid    = 1'b0;
        bus.key          = '0;
        bus.decrypt      = 1'b0;
        bus.subkey_ready = 1'b1;
        #12;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        load_key(KEY_A, 1'b0);
        collect("enc", 1'b0, -1, 0, -1, -1);

        load_key(KEY_A, 1'b1);
        collect("dec", 1'b1, -1, 0, -1, -1);

        load_key(KEY_A, 1'b0);
        collect("bp", 1'b0, 7, 5, -1, -1);

        load_key(KEY_B, 1'b0);
        collect("parity", 1'b0, -1, 0, -1, -1);

        load_key(KEY_A, 1'b0);
        collect("busykey", 1'b0, -1, 0, 4, -1);

        load_key(KEY_A, 1'b0);
        collect("prerst", 1'b0, -1, 0, -1, 9);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("midrun reset");
        @(negedge clk);
        rst_n = 1'b1;
        load_key(KEY_A, 1'b0);
        collect("postrst", 1'b0, -1, 0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
